stack_path_drain: RTL and testbench

- Downstream consumer of the 2-bit-wide stack (256 entries).
- After the upstream search logic has pushed a path of 2-bit moves, a start pulse makes this block pop every entry in LIFO order.
- Each move is presented on a valid/ready output stream to the move executor, with a count of moves and a completion pulse.
- Owns the stack Pop line during draining; never pushes.

---
 rtl/stack_path_drain.sv | 117 +++++++++++
 tb/tb_stack_path_drain.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_path_drain.sv
// Pops a pushed path of 2-bit moves off the external stack in LIFO order and
// hands each one to the move executor over a valid/ready stream.
module stack_path_drain #(
  parameter int DEPTH      = 256,
  parameter int CNT_W      = 9,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       stk_top,
  input  logic             stk_empty,
  output logic             stk_pop,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [1:0]       mv_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] move_count
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, SETTLE, PRESENT, POP, DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             stk_pop_d, mv_valid_d, busy_d, done_d;
  logic [1:0]       mv_data_d;
  logic [CNT_W-1:0] move_count_d;

  // NOTE: every signal gets a default first so no path through the case
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    stk_pop_d    = 1'b0;
    done_d       = 1'b0;
    mv_valid_d   = mv_valid;
    mv_data_d    = mv_data;
    move_count_d = move_count;

    if (abort) begin
      state_d    = IDLE;
      mv_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d      = SETTLE;
            settle_d     = SETTLE_LOAD;
            move_count_d = '0;
          end
        end
        SETTLE: begin
          // stk_top/stk_empty trail the pointer, so only trust them on the last cycle
          if (settle_q == '0) begin
            if (stk_empty) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d    = PRESENT;
              mv_data_d  = stk_top;
              mv_valid_d = 1'b1;
            end
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        PRESENT: begin
          if (mv_ready) begin
            state_d    = POP;
            mv_valid_d = 1'b0;
            stk_pop_d  = 1'b1;
            if (move_count != CNT_MAX) move_count_d = move_count + 1'b1;
          end
        end
        POP: begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      stk_pop    <= 1'b0;
      mv_valid   <= 1'b0;
      mv_data    <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      move_count <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      stk_pop    <= stk_pop_d;
      mv_valid   <= mv_valid_d;
      mv_data    <= mv_data_d;
      busy       <= busy_d;
      done       <= done_d;
      move_count <= move_count_d;
    end
  end

endmodule

// File: tb/tb_stack_path_drain.sv
// Bench for stack_path_drain: a behavioural stack plus a LIFO scoreboard,
// table-driven random drains, and directed multi-cycle corner cases.
module tb_stack_path_drain;

  localparam int DEPTH      = 256;
  localparam int CNT_W      = 9;
  localparam int SETTLE_CYC = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, abort = 1'b0, mv_ready = 1'b0;
  logic [1:0]       stk_top = 2'b00;
  logic             stk_empty = 1'b1;
  logic             stk_pop, mv_valid, busy, done;
  logic [1:0]       mv_data;
  logic [CNT_W-1:0] move_count;

  stack_path_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .stk_top(stk_top), .stk_empty(stk_empty), .stk_pop(stk_pop),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_data(mv_data),
    .busy(busy), .done(done), .move_count(move_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stack model: pointer moves on the edge that sees pop/push, outputs one edge later.
  logic [1:0] mem [DEPTH];
  int         sp = 0;
  int         pop_total = 0;
  int         underflow = 0;
  logic       push_en = 1'b0, stk_clear = 1'b0;
  logic [1:0] push_d = 2'b00;

  always @(posedge clk) begin
    if (stk_clear) sp <= 0;
    else if (stk_pop) begin
      pop_total <= pop_total + 1;
      if (sp == 0) underflow <= underflow + 1;
      else sp <= sp - 1;
    end else if (push_en) begin
      mem[sp] <= push_d;
      sp      <= sp + 1;
    end
    stk_top   <= (sp > 0) ? mem[sp-1] : 2'b00;
    stk_empty <= (sp == 0);
  end

  // Scoreboard: moves must come out in reverse push order.
  logic [1:0] exp_q[$];
  int  hs_total = 0;
  int  cyc = 0;
  int  last_hs = -1;
  int  gap_bad = 0;
  bit  gap_en = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst && mv_valid && mv_ready) begin
      hs_total++;
      if (exp_q.size() == 0) check("unexpected_move", 1, 0);
      else check("mv_data_order", mv_data, exp_q.pop_back());
      if (gap_en) begin
        if (last_hs >= 0 && (cyc - last_hs) != 4) gap_bad++;
        last_hs = cyc;
      end
    end
    if (!gap_en) last_hs = -1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v);
    push_en = 1'b1;
    push_d  = v;
    exp_q.push_back(v);
    tick();
    push_en = 1'b0;
  endtask

  task automatic clear_stack();
    stk_clear = 1'b1;
    tick();
    stk_clear = 1'b0;
    tick();
    exp_q.delete();
  endtask

  task automatic wait_done(input int pct, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      mv_ready = ($urandom_range(99) < pct);
      tick();
      if (done) seen = 1;
    end
    mv_ready = 1'b0;
    check("drain_finished", seen, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    int n;
    int ready_pct;
    int exp_count;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int p0, h0;
    bit bad;
    logic [1:0] d0;

    vecs[0] = '{n: 3,  ready_pct: 100, exp_count: 3};
    vecs[1] = '{n: 0,  ready_pct: 100, exp_count: 0};
    vecs[2] = '{n: 1,  ready_pct: 60,  exp_count: 1};
    vecs[3] = '{n: 9,  ready_pct: 40,  exp_count: 9};
    vecs[4] = '{n: 30, ready_pct: 25,  exp_count: 30};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_stk_pop", stk_pop, 0);
    check("rst_mv_valid", mv_valid, 0);
    check("rst_mv_data", mv_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_move_count", move_count, 0);
    rst = 1'b0;
    tick();

    // Directed three-move drain with first-move latency
    clear_stack();
    push(2'b01); push(2'b10); push(2'b11);
    tick();
    p0 = pop_total;
    mv_ready = 1'b1;
    pulse_start();
    for (int i = 1; i < SETTLE_CYC; i++) tick();
    check("first_mv_not_early", mv_valid, 0);
    tick();
    check("first_mv_valid", mv_valid, 1);
    check("first_mv_data", mv_data, 2'b11);
    wait_done(100, 100);
    check("three_count", move_count, 3);
    check("three_pops", pop_total - p0, 3);
    tick();
    check("three_empty_after", stk_empty, 1);

    // Empty stack: done on the SETTLE_CYC-th edge after the start edge
    clear_stack();
    p0 = pop_total;
    mv_ready = 1'b1;
    bad = 0;
    pulse_start();
    for (int i = 1; i < SETTLE_CYC; i++) begin
      if (done || mv_valid) bad = 1;
      tick();
    end
    check("empty_no_early_done", bad, 0);
    check("empty_busy", busy, 1);
    tick();
    check("empty_done", done, 1);
    check("empty_mv_valid", mv_valid, 0);
    check("empty_count", move_count, 0);
    tick();
    check("empty_done_one_cycle", done, 0);
    check("empty_idle", busy, 0);
    check("empty_no_pop", pop_total - p0, 0);
    mv_ready = 1'b0;

    // Back-pressure: move held stable while mv_ready is low
    clear_stack();
    push(2'b10); push(2'b01);
    tick();
    p0 = pop_total;
    pulse_start();
    for (int i = 0; i < 20 && !mv_valid; i++) tick();
    d0 = mv_data;
    check("stall_first_data", d0, 2'b01);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!mv_valid || mv_data !== d0) bad = 1;
    end
    check("stall_stable", bad, 0);
    check("stall_no_pop", pop_total - p0, 0);
    wait_done(100, 100);
    check("stall_count", move_count, 2);

    // Table-driven random drains
    foreach (vecs[k]) begin
      clear_stack();
      for (int i = 0; i < vecs[k].n; i++) push(2'($urandom_range(3)));
      tick();
      p0 = pop_total;
      h0 = hs_total;
      pulse_start();
      wait_done(vecs[k].ready_pct, 2000);
      check("vec_count", move_count, vecs[k].exp_count);
      check("vec_handshakes", hs_total - h0, vecs[k].n);
      check("vec_pops", pop_total - p0, vecs[k].n);
      check("vec_model_drained", exp_q.size(), 0);
    end

    // Full stack, alternating codes, steady one-move-per-4-cycles
    clear_stack();
    for (int i = 0; i < DEPTH; i++) push((i % 2) ? 2'b11 : 2'b00);
    tick();
    p0 = pop_total;
    h0 = hs_total;
    gap_en = 1;
    mv_ready = 1'b1;
    pulse_start();
    wait_done(100, 2000);
    gap_en = 0;
    check("full_count", move_count, 256);
    check("full_handshakes", hs_total - h0, 256);
    check("full_pops", pop_total - p0, 256);
    check("full_spacing", gap_bad, 0);

    // Abort after the 2nd handshake, then resume draining
    clear_stack();
    for (int i = 0; i < 5; i++) push(2'($urandom_range(3)));
    tick();
    h0 = hs_total;
    mv_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 50 && (hs_total - h0) < 2; i++) tick();
    abort = 1'b1;
    mv_ready = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_mv_valid", mv_valid, 0);
    check("abort_stk_pop", stk_pop, 0);
    check("abort_count", move_count, 2);
    tick();
    check("abort_stack_left", sp, 3);
    pulse_start();
    wait_done(100, 100);
    check("resume_count", move_count, 3);
    check("resume_model_drained", exp_q.size(), 0);

    // abort and start together: stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("abort_beats_start", busy, 0);

    // Extra start while busy is ignored; async reset mid-PRESENT
    clear_stack();
    push(2'b11); push(2'b10);
    tick();
    pulse_start();
    for (int i = 0; i < 20 && !mv_valid; i++) tick();
    pulse_start();
    tick();
    check("restart_ignored_valid", mv_valid, 1);
    check("restart_ignored_data", mv_data, exp_q[exp_q.size()-1]);
    check("restart_ignored_count", move_count, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mv_valid", mv_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_stk_pop", stk_pop, 0);
    tick();
    rst = 1'b0;
    clear_stack();

    check("no_pop_when_empty", underflow, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
